// File: rtl/throw_charge_ctl_pkg.sv
// Shared types and constants for the throw power meter and its neighbours.
package throw_charge_ctl_pkg;

    localparam int FORCE_W       = 10;
    localparam int RAMP_W        = FORCE_W + 1;  // one spare bit so level+STEP never wraps
    localparam int DEF_MAX_FORCE = 1000;
    localparam int DEF_MIN_FORCE = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_HOLD,
        ST_COOLDOWN
    } charge_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } ramp_dir_t;

    typedef struct packed {
        logic [FORCE_W-1:0] level;
        ramp_dir_t          dir;
    } ramp_t;

    localparam ramp_t RAMP_IDLE = '{level: '0, dir: DIR_UP};

    // One ramp tick: bounce between 0 and max_force, clamping at both ends.
    function automatic ramp_t ramp_next(input ramp_t cur,
                                        input logic [RAMP_W-1:0] step,
                                        input logic [RAMP_W-1:0] max_force);
        ramp_t              nxt;
        logic [RAMP_W-1:0]  lvl;
        logic [RAMP_W-1:0]  sum;
        logic [RAMP_W-1:0]  diff;
        nxt  = cur;
        lvl  = {1'b0, cur.level};
        sum  = lvl + step;
        diff = lvl - step;
        if (cur.dir == DIR_UP) begin
            if (sum >= max_force) begin
                nxt.level = max_force[FORCE_W-1:0];
                nxt.dir   = DIR_DOWN;
            end else begin
                nxt.level = sum[FORCE_W-1:0];
            end
        end else begin
            if (lvl <= step) begin
                nxt.level = '0;
                nxt.dir   = DIR_UP;
            end else begin
                nxt.level = diff[FORCE_W-1:0];
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/throw_charge_ctl_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_gen #(
    parameter int DIV = 65000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..DIV-1 and wrap; restarts from 0 on reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/throw_charge_ctl.sv
// Power meter: ramps a force while the button is held, latches it on release
// and holds the throw request until the flight ends or times out.
module throw_charge_ctl
    import throw_charge_ctl_pkg::*;
#(
    parameter int TICK_DIV    = 65000,
    parameter int STEP        = 8,
    parameter int MAX_FORCE   = DEF_MAX_FORCE,
    parameter int MIN_FORCE   = DEF_MIN_FORCE,
    parameter int TIMEOUT_MS  = 5000,
    parameter int COOLDOWN_MS = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_left,
    input  logic               turn_en,
    input  logic               throw_done,
    output logic [FORCE_W-1:0] throw_force,
    output logic               throw_enable,
    output logic [FORCE_W-1:0] charge_level,
    output logic               charging,
    output logic               busy
);

    localparam int TMR_MAX = (TIMEOUT_MS > COOLDOWN_MS) ? TIMEOUT_MS : COOLDOWN_MS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]   TIMEOUT_CNT  = TMR_W'(TIMEOUT_MS);
    localparam logic [TMR_W-1:0]   COOLDOWN_CNT = TMR_W'(COOLDOWN_MS);
    localparam logic [FORCE_W-1:0] MIN_LVL      = FORCE_W'(MIN_FORCE);
    localparam logic [RAMP_W-1:0]  STEP_R       = RAMP_W'(STEP);
    localparam logic [RAMP_W-1:0]  MAX_R        = RAMP_W'(MAX_FORCE);

    charge_state_t      state, state_n;
    ramp_t              ramp, ramp_n;
    logic [TMR_W-1:0]   timer, timer_n, timer_cnt;
    logic [FORCE_W-1:0] force_n;
    logic               enable_n;
    logic               btn_d;
    logic               tick;
    logic               press, release_e;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign press        = btn_left & ~btn_d;
    assign release_e    = ~btn_left & btn_d;
    assign charge_level = ramp.level;

    // Next-state, ramp, timer and throw latch decisions.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_n   = state;
        ramp_n    = ramp;
        timer_n   = timer;
        force_n   = throw_force;
        enable_n  = throw_enable;
        timer_cnt = tick ? timer + 1'b1 : timer;

        case (state)
            ST_IDLE: begin
                ramp_n = RAMP_IDLE;
                if (press && turn_en) begin
                    state_n = ST_CHARGE;
                end
            end
            ST_CHARGE: begin
                if (!turn_en) begin
                    state_n = ST_IDLE;
                    ramp_n  = RAMP_IDLE;
                end else if (release_e) begin
                    if (ramp.level < MIN_LVL) begin
                        state_n = ST_IDLE;
                        ramp_n  = RAMP_IDLE;
                    end else begin
                        // Latch the pre-tick level; a coinciding tick is dropped.
                        force_n  = ramp.level;
                        enable_n = 1'b1;
                        timer_n  = '0;
                        state_n  = ST_HOLD;
                    end
                end else if (tick) begin
                    ramp_n = ramp_next(ramp, STEP_R, MAX_R);
                end
            end
            ST_HOLD: begin
                timer_n = timer_cnt;
                if (throw_done || timer_cnt == TIMEOUT_CNT) begin
                    enable_n = 1'b0;
                    timer_n  = '0;
                    state_n  = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                timer_n = timer_cnt;
                if (timer_cnt == COOLDOWN_CNT) begin
                    timer_n = '0;
                    ramp_n  = RAMP_IDLE;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                ramp_n  = RAMP_IDLE;
            end
        endcase
    end

    // State, edge-detect and registered outputs; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            btn_d        <= 1'b0;
            ramp         <= RAMP_IDLE;
            timer        <= '0;
            throw_force  <= '0;
            throw_enable <= 1'b0;
            charging     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            btn_d        <= btn_left;
            ramp         <= ramp_n;
            timer        <= timer_n;
            throw_force  <= force_n;
            throw_enable <= enable_n;
            charging     <= (state_n == ST_CHARGE);
            busy         <= (state_n == ST_HOLD) || (state_n == ST_COOLDOWN);
        end
    end

endmodule

// File: tb/tb_throw_charge_ctl.sv
// Scoreboard bench for throw_charge_ctl: a behavioural model predicts every
// cycle's outputs and each latched throw force; a monitor compares on the
// falling edge.
module tb_throw_charge_ctl;

    localparam int TICK_DIV = 4;
    localparam int STEP     = 100;
    localparam int MAXF     = 1000;
    localparam int MINF     = 40;
    localparam int TIMEOUT  = 20;
    localparam int COOL     = 3;

    localparam int MD_IDLE = 0, MD_CHARGE = 1, MD_HOLD = 2, MD_COOL = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0;
    logic       turn_en = 1'b0;
    logic       throw_done = 1'b0;
    logic [9:0] throw_force;
    logic       throw_enable;
    logic [9:0] charge_level;
    logic       charging;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [22:0] exp_q[$];
    int          throw_q[$];

    throw_charge_ctl #(
        .TICK_DIV    (TICK_DIV),
        .STEP        (STEP),
        .MAX_FORCE   (MAXF),
        .MIN_FORCE   (MINF),
        .TIMEOUT_MS  (TIMEOUT),
        .COOLDOWN_MS (COOL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_left     (btn_left),
        .turn_en      (turn_en),
        .throw_done   (throw_done),
        .throw_force  (throw_force),
        .throw_enable (throw_enable),
        .charge_level (charge_level),
        .charging     (charging),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Triangle wave reached after n ramp ticks: up in STEP increments to MAXF
    // (clamped), back down to 0, repeating.
    function automatic int tri_level(input int n);
        int u, m;
        u = (MAXF + STEP - 1) / STEP;
        m = n % (2 * u);
        if (m <= u) return (m * STEP > MAXF) ? MAXF : m * STEP;
        return MAXF - (m - u) * STEP;
    endfunction

    // ---------------- reference model ----------------
    int   m_mode = MD_IDLE;
    int   m_cyc = 0, m_n = 0, m_t = 0, m_level = 0, m_force = 0;
    logic m_en = 1'b0, m_prev = 1'b0, m_tick = 1'b0;

    always @(posedge clk) begin
        logic press, rel;
        if (!rst_n) begin
            m_mode = MD_IDLE; m_cyc = 0; m_n = 0; m_t = 0;
            m_level = 0; m_force = 0; m_en = 1'b0; m_prev = 1'b0; m_tick = 1'b0;
        end else begin
            m_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
            m_cyc++;
            press = btn_left & ~m_prev;
            rel   = ~btn_left & m_prev;
            case (m_mode)
                MD_IDLE: begin
                    m_level = 0;
                    if (press && turn_en) begin m_mode = MD_CHARGE; m_n = 0; end
                end
                MD_CHARGE: begin
                    if (!turn_en) begin
                        m_mode = MD_IDLE; m_level = 0;
                    end else if (rel) begin
                        if (m_level < MINF) begin
                            m_mode = MD_IDLE; m_level = 0;
                        end else begin
                            m_force = m_level; m_en = 1'b1; m_t = 0; m_mode = MD_HOLD;
                            throw_q.push_back(m_level);
                        end
                    end else if (m_tick) begin
                        m_n++;
                        m_level = tri_level(m_n);
                    end
                end
                MD_HOLD: begin
                    if (m_tick) m_t++;
                    if (throw_done || m_t == TIMEOUT) begin
                        m_en = 1'b0; m_t = 0; m_mode = MD_COOL;
                    end
                end
                default: begin
                    if (m_tick) m_t++;
                    if (m_t == COOL) begin m_mode = MD_IDLE; m_level = 0; end
                end
            endcase
            m_prev = btn_left;
        end
        exp_q.push_back({m_en, 10'(m_force), 10'(m_level),
                         (m_mode == MD_CHARGE), (m_mode == MD_HOLD || m_mode == MD_COOL)});
    end

    // ---------------- monitor ----------------
    logic mon_prev_en = 1'b0;
    always @(negedge clk) begin
        logic [22:0] e;
        int          ef;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", {9'd0, throw_enable, throw_force, charge_level, charging, busy},
                  {9'd0, e});
        end
        if (throw_enable && !mon_prev_en) begin
            ef = (throw_q.size() > 0) ? throw_q.pop_front() : -1;
            check("throw_force_latch", {22'd0, throw_force}, ef);
        end
        mon_prev_en = throw_enable;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ticks(input int k);
        int seen = 0;
        int budget = (k + 1) * TICK_DIV + 2;
        while (seen < k && budget > 0) begin
            step();
            budget--;
            if (m_tick) seen++;
        end
    endtask

    task automatic finish_throw();
        throw_done = 1'b1; step(); throw_done = 1'b0;
        wait_ticks(COOL);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        step(); step();
        check("reset_outputs", {throw_enable, throw_force, charge_level, charging, busy}, 0);
        rst_n = 1'b1;
        turn_en = 1'b1;

        // 1: five ticks of charge -> 500
        btn_left = 1'b1; step();
        check("t1_charging", charging, 1);
        wait_ticks(5);
        check("t1_no_enable_before_release", throw_enable, 0);
        btn_left = 1'b0; step();
        check("t1_force", throw_force, 500);
        check("t1_enable", throw_enable, 1);
        check("t1_charging_low", charging, 0);
        check("t1_busy", busy, 1);
        finish_throw();

        // 2: twelve ticks -> past the ceiling and back down to 800
        btn_left = 1'b1; step();
        wait_ticks(12);
        btn_left = 1'b0; step();
        check("t2_force", throw_force, 800);
        finish_throw();

        // 3: release before any tick aborts
        btn_left = 1'b1; step();
        btn_left = 1'b0; step();
        check("t3_no_enable", throw_enable, 0);
        check("t3_idle", charging, 0);
        step(); step();
        check("t3_still_no_enable", throw_enable, 0);

        // 4: throw_done ends hold; held button must not re-arm
        btn_left = 1'b1; step();
        wait_ticks(3);
        btn_left = 1'b0; step();
        btn_left = 1'b1; step(); step();
        check("t4_hold_ignores_btn", {charging, busy, throw_enable}, 3'b011);
        throw_done = 1'b1; step(); throw_done = 1'b0;
        check("t4_enable_drop", throw_enable, 0);
        check("t4_busy_cool", busy, 1);
        wait_ticks(2);
        check("t4_busy_2ticks", busy, 1);
        wait_ticks(1);
        check("t4_busy_done", busy, 0);
        step(); step(); step();
        check("t4_held_no_charge", charging, 0);
        btn_left = 1'b0; step();
        btn_left = 1'b1; step();
        check("t4_repress_charges", charging, 1);

        // 5b: turn ends mid-charge
        wait_ticks(2);
        turn_en = 1'b0; step();
        check("t5_turn_abort", {charging, throw_enable, charge_level}, 0);
        turn_en = 1'b1; btn_left = 1'b0; step();

        // 5a: timeout without throw_done
        btn_left = 1'b1; step();
        wait_ticks(4);
        btn_left = 1'b0; step();
        check("t5_force", throw_force, 400);
        wait_ticks(TIMEOUT - 1);
        check("t5_enable_before_timeout", throw_enable, 1);
        wait_ticks(1);
        check("t5_enable_timeout", throw_enable, 0);
        check("t5_busy_cool", busy, 1);
        wait_ticks(COOL);

        // 6: reset during hold
        btn_left = 1'b1; step();
        wait_ticks(2);
        btn_left = 1'b0; step();
        step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("t6_reset_clears", {throw_enable, throw_force, charge_level, charging, busy}, 0);
        btn_left = 1'b1; step();
        check("t6_restart", {charging, charge_level}, {1'b1, 10'd0});
        wait_ticks(1);
        check("t6_first_step", charge_level, 100);
        turn_en = 1'b0; step();
        turn_en = 1'b1; btn_left = 1'b0; step();

        // Random phase checked only by the scoreboard
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) btn_left = ~btn_left;
            turn_en    = ($urandom_range(0, 59) != 0);
            throw_done = ($urandom_range(0, 24) == 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            step();
        end

        rst_n = 1'b1; btn_left = 1'b0; throw_done = 1'b0;
        step(); step(); step();
        check("throw_queue_drained", throw_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/throw_charge_ctl.md
Name: throw_charge_ctl

Overview:
- Power-meter stage directly upstream of the projectile trajectory controller.
- While the player holds the left mouse button, it ramps a force value up and down between 0 and MAX_FORCE.
- On release it latches that value onto throw_force and holds throw_enable high until the flight finishes (throw_done) or a timeout expires.
- After a cooldown it re-arms; charge_level also drives the on-screen power bar.

Parameters:
TICK_DIV, 65000, clk cycles per ramp tick (1 ms at 65 MHz)
STEP, 8, force increment/decrement per tick
MAX_FORCE, 1000, ramp ceiling (must be <= 1023)
MIN_FORCE, 40, release below this aborts the throw
TIMEOUT_MS, 5000, max ticks throw_enable stays high without throw_done
COOLDOWN_MS, 200, ticks spent in COOLDOWN before re-arming

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
btn_left  in  1  left mouse button level, already in clk domain
turn_en  in  1  high while it is this player's turn
throw_done  in  1  one-cycle pulse from trajectory stage: projectile finished
throw_force  out  10  latched force for trajectory stage
throw_enable  out  1  throw request/hold to trajectory stage
charge_level  out  10  live ramp value for power-bar rendering
charging  out  1  high in CHARGE
busy  out  1  high in HOLD or COOLDOWN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. While rst_n=0, at each edge: state=IDLE, tick counter=0, btn_d=0, dir=up, and all outputs are 0.
- Tick generator: free-running counter 0..TICK_DIV-1. tick is a one-cycle pulse when the counter equals TICK_DIV-1; the counter then wraps to 0.
- Edge detection: btn_d registers btn_left.
  - press = btn_left & ~btn_d
  - release = ~btn_left & btn_d
- IDLE:
  - charge_level=0, dir=up.
  - press & turn_en: go to CHARGE.
  - A button already held on entry does nothing; a new press edge is required.
- CHARGE:
  - On tick, ramp charge_level:
    - dir=up and level+STEP >= MAX_FORCE: level=MAX_FORCE, dir=down.
    - dir=down and level <= STEP: level=0, dir=up.
    - Otherwise: level ± STEP.
  - Ramp arithmetic is done in 11 bits; no wrap past 0 or MAX_FORCE.
  - Priority, highest first:
    1. turn_en=0: abort to IDLE; no enable is issued.
    2. release with level < MIN_FORCE: go to IDLE; no enable is issued.
    3. release with level >= MIN_FORCE: throw_force <= charge_level (pre-tick value if tick coincides), throw_enable <= 1, go to HOLD.
  - Latency: throw_enable is visible one cycle after the release is sampled.
- HOLD:
  - throw_force is stable; throw_enable=1.
  - The timeout counter counts ticks.
  - throw_done=1 or timeout count reaches TIMEOUT_MS: throw_enable <= 0, go to COOLDOWN.
  - btn_left and turn_en are ignored in HOLD.
- COOLDOWN:
  - After COOLDOWN_MS ticks, go to IDLE.
  - throw_force keeps its last value until the next latch.
- throw_done outside HOLD is ignored.
- charging=(state==CHARGE); busy=(state==HOLD || state==COOLDOWN). Both are registered.
- Reset mid-operation (any state): return to IDLE with outputs 0 on the same edge.

Decomposition:
- vga_pkg or a new game_pkg holds:
  - the state typedef charge_state_t {ST_IDLE, ST_CHARGE, ST_HOLD, ST_COOLDOWN}
  - FORCE_W=10
  - the default MAX_FORCE/MIN_FORCE constants
- One sub-module: tick_gen (parameter DIV; outputs the tick pulse). It is reusable for the ms counter the trajectory stage already needs.

Test Plan:
(Bench parameters: TICK_DIV=4, STEP=100, MAX_FORCE=1000, MIN_FORCE=40, TIMEOUT_MS=20, COOLDOWN_MS=3.)
1. turn_en=1; press, hold 5 ticks, release -> throw_force=500; throw_enable=1 one cycle after release; charging falls, busy rises.
2. Hold 12 ticks -> ramp 100..1000 then 900, 800; release -> throw_force=800.
3. Press and release before the first tick (level 0 < 40) -> throw_enable never asserts; state returns to IDLE.
4. throw_done pulse in HOLD -> throw_enable=0 next cycle; busy high for 3 ticks then low. btn_left held throughout -> no new CHARGE until release then press.
5. No throw_done -> throw_enable drops after 20 ticks; turn_en=0 mid-CHARGE -> immediate IDLE, charge_level=0, no enable.
6. rst_n=0 for one edge during HOLD -> throw_enable, throw_force, busy, charge_level all 0; a subsequent press starts cleanly from 0.
